// File: rtl/skein_pkg.sv
// Shared Threefish-1024 key-schedule constants, the sequencer state type and
// the small modular helpers used to derive key and tweak word indices.
package skein_pkg;

  localparam int WORDS       = 16;
  localparam int KEY_WORDS   = 17;
  localparam int SUBKEYS     = 21;
  localparam int TWEAK_WORDS = 3;

  // Word positions that receive tweak words and the subkey counter.
  localparam logic [3:0] WORD_TWEAK0 = 4'd13;
  localparam logic [3:0] WORD_TWEAK1 = 4'd14;
  localparam logic [3:0] WORD_LAST   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_t;

  function automatic logic [4:0] mod17(input logic [4:0] v);
    return (v >= 5'(KEY_WORDS)) ? v - 5'(KEY_WORDS) : v;
  endfunction

  // Inputs never exceed 21, so three conditional subtractions suffice.
  function automatic logic [1:0] mod3(input logic [4:0] v);
    logic [4:0] r;
    r = v;
    if (r >= 5'd12) r = r - 5'd12;
    if (r >= 5'd6)  r = r - 5'd6;
    if (r >= 5'd3)  r = r - 5'd3;
    return r[1:0];
  endfunction

endpackage

// File: rtl/subkey_word_sequencer_if.sv
// Per-word subkey control beat. valid_o/ready_i: a beat transfers on a rising
// edge where both are high; once valid_o rises the beat holds until it transfers.
interface subkey_word_sequencer_if;
  logic       valid_o;
  logic       ready_i;
  logic [3:0] select_o;
  logic [4:0] key_idx_o;
  logic       tweak_en_o;
  logic [1:0] tweak_idx_o;
  logic       count_en_o;
  logic       last_o;

  modport master (
    output valid_o, select_o, key_idx_o, tweak_en_o, tweak_idx_o, count_en_o, last_o,
    input  ready_i
  );

  modport slave (
    input  valid_o, select_o, key_idx_o, tweak_en_o, tweak_idx_o, count_en_o, last_o,
    output ready_i
  );
endinterface

// File: rtl/subkey_index_counter.sv
// Key-schedule word index: loads a starting index and counts 0..16 with wrap.
module subkey_index_counter
  import skein_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       load_i,
  input  logic [4:0] load_val_i,
  input  logic       inc_i,
  output logic [4:0] idx_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_o <= 5'd0;
    end else if (load_i) begin
      idx_o <= load_val_i;
    end else if (inc_i) begin
      idx_o <= (idx_o == 5'(KEY_WORDS - 1)) ? 5'd0 : idx_o + 5'd1;
    end
  end

endmodule

// File: rtl/subkey_word_sequencer.sv
// Walks the 16 word positions of one subkey injection, issuing key index,
// tweak index and counter-add flags as valid/ready beats.
module subkey_word_sequencer
  import skein_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic [4:0]              subkey_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output seq_state_t              state_o,
  subkey_word_sequencer_if.master bus
);

  localparam logic [4:0] SUBKEY_LIMIT = 5'(SUBKEYS);

  seq_state_t state_q;
  logic [3:0] select_q;
  logic [1:0] tweak0_q;
  logic [1:0] tweak1_q;
  logic       err_q;
  logic       issuing;
  logic       accept;
  logic       transfer;

  assign issuing  = (state_q == ST_ISSUE);
  assign accept   = (state_q == ST_IDLE) && start_i && (subkey_i < SUBKEY_LIMIT);
  assign transfer = issuing && bus.ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      select_q <= 4'd0;
      tweak0_q <= 2'd0;
      tweak1_q <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (subkey_i < SUBKEY_LIMIT) begin
              state_q  <= ST_ISSUE;
              select_q <= 4'd0;
              // Tweak indices are fixed for the whole injection.
              tweak0_q <= mod3(subkey_i);
              tweak1_q <= mod3(subkey_i + 5'd1);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (bus.ready_i) begin
            if (select_q == WORD_LAST) state_q <= ST_DONE;
            else                       select_q <= select_q + 4'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  subkey_index_counter u_key_idx (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (accept),
    .load_val_i (mod17(subkey_i)),
    .inc_i      (transfer && (select_q != WORD_LAST)),
    .idx_o      (bus.key_idx_o)
  );

  // Word-specific flags are gated by ISSUE so DONE/IDLE never show a stale word 15.
  assign bus.valid_o     = issuing;
  assign bus.select_o    = select_q;
  assign bus.tweak_en_o  = issuing && ((select_q == WORD_TWEAK0) || (select_q == WORD_TWEAK1));
  assign bus.tweak_idx_o = !issuing                   ? 2'd0 :
                           (select_q == WORD_TWEAK0)  ? tweak0_q :
                           (select_q == WORD_TWEAK1)  ? tweak1_q : 2'd0;
  assign bus.count_en_o  = issuing && (select_q == WORD_LAST);
  assign bus.last_o      = issuing && (select_q == WORD_LAST);
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = (state_q == ST_DONE);
  assign err_o           = err_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_subkey_word_sequencer.sv
// Directed bench for subkey_word_sequencer: table of subkey runs plus
// hand-written reset, error and start-during-issue sequences.
module tb_subkey_word_sequencer;
  import skein_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       start_i = 1'b0;
  logic [4:0] subkey_i = 5'd0;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  seq_state_t state_o;

  subkey_word_sequencer_if bus();

  subkey_word_sequencer dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n_i),
    .start_i  (start_i),
    .subkey_i (subkey_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .state_o  (state_o),
    .bus      (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    logic [4:0] s;
    bit         toggle;
    bit         poke_start;
    logic [4:0] k0;
    logic [1:0] t13;
    logic [1:0] t14;
    int         cycles;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid"},     32'(bus.valid_o),     0);
    chk({tag, "_select"},    32'(bus.select_o),    0);
    chk({tag, "_key_idx"},   32'(bus.key_idx_o),   0);
    chk({tag, "_tweak_en"},  32'(bus.tweak_en_o),  0);
    chk({tag, "_tweak_idx"}, 32'(bus.tweak_idx_o), 0);
    chk({tag, "_count_en"},  32'(bus.count_en_o),  0);
    chk({tag, "_last"},      32'(bus.last_o),      0);
    chk({tag, "_busy"},      32'(busy_o),          0);
    chk({tag, "_done"},      32'(done_o),          0);
    chk({tag, "_err"},       32'(err_o),           0);
    chk({tag, "_state"},     32'(state_o),         32'(ST_IDLE));
  endtask

  // Driver + scoreboard for one full injection described by a table entry.
  task automatic run_seq(input vec_t v);
    logic [4:0] k;
    int beat;
    int cyc;
    logic r;
    exp_q.delete();
    k = v.k0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(k);
      k = (k == 5'd16) ? 5'd0 : k + 5'd1;
    end
    start_i  = 1'b1;
    subkey_i = v.s;
    tick;
    start_i = 1'b0;
    chk("busy_at_start", 32'(busy_o), 1);
    beat = 0;
    cyc  = 0;
    while (beat < 16 && cyc < 100) begin
      r = v.toggle ? ((cyc % 2) == 0) : 1'b1;
      bus.ready_i = r;
      start_i  = v.poke_start && (beat == 3);
      subkey_i = 5'd2;
      chk("valid",     32'(bus.valid_o),     1);
      chk("select",    32'(bus.select_o),    32'(beat));
      chk("key_idx",   32'(bus.key_idx_o),   32'(exp_q[0]));
      chk("tweak_en",  32'(bus.tweak_en_o),  32'(beat == 13 || beat == 14));
      chk("tweak_idx", 32'(bus.tweak_idx_o), beat == 13 ? 32'(v.t13) : beat == 14 ? 32'(v.t14) : 0);
      chk("count_en",  32'(bus.count_en_o),  32'(beat == 15));
      chk("last",      32'(bus.last_o),      32'(beat == 15));
      chk("done_mid",  32'(done_o),          0);
      tick;
      if (r) begin
        void'(exp_q.pop_front());
        beat++;
      end
      cyc++;
    end
    start_i = 1'b0;
    bus.ready_i = 1'b0;
    chk("beats",         32'(beat),        16);
    chk("cycles",        32'(cyc),         32'(v.cycles));
    chk("done_pulse",    32'(done_o),      1);
    chk("valid_in_done", 32'(bus.valid_o), 0);
    chk("busy_in_done",  32'(busy_o),      1);
    chk("last_in_done",  32'(bus.last_o),  0);
    tick;
    chk("done_cleared",  32'(done_o),      0);
    chk("busy_idle",     32'(busy_o),      0);
    chk("state_idle",    32'(state_o),     32'(ST_IDLE));
  endtask

  initial begin
    //           s      toggle poke  k0     t13   t14   cycles
    vecs[0] = '{5'd0,  1'b0, 1'b0, 5'd0,  2'd0, 2'd1, 16};
    vecs[1] = '{5'd5,  1'b0, 1'b0, 5'd5,  2'd2, 2'd0, 16};
    vecs[2] = '{5'd20, 1'b0, 1'b0, 5'd3,  2'd2, 2'd0, 16};
    vecs[3] = '{5'd9,  1'b1, 1'b0, 5'd9,  2'd0, 2'd1, 31};
    vecs[4] = '{5'd16, 1'b0, 1'b1, 5'd16, 2'd1, 2'd2, 16};
    vecs[5] = '{5'd17, 1'b1, 1'b1, 5'd0,  2'd2, 2'd0, 31};

    bus.ready_i = 1'b0;
    tick;
    tick;
    chk_reset_values("reset");
    rst_n_i = 1'b1;
    tick;

    // Out-of-range subkeys raise a one-cycle error and never start.
    for (int e = 0; e < 2; e++) begin
      start_i  = 1'b1;
      subkey_i = (e == 0) ? 5'd21 : 5'd31;
      tick;
      start_i = 1'b0;
      chk("err_pulse",  32'(err_o),       1);
      chk("err_busy",   32'(busy_o),      0);
      chk("err_valid",  32'(bus.valid_o), 0);
      tick;
      chk("err_cleared", 32'(err_o),      0);
      chk("err_idle",    32'(busy_o),     0);
    end

    foreach (vecs[i]) run_seq(vecs[i]);

    // Reset while word 7 is on the bus.
    bus.ready_i = 1'b1;
    start_i  = 1'b1;
    subkey_i = 5'd0;
    tick;
    start_i = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    chk("pre_reset_select", 32'(bus.select_o), 7);
    bus.ready_i = 1'b0;
    rst_n_i = 1'b0;
    #1;
    chk_reset_values("mid_reset");
    tick;
    tick;
    chk("no_done_after_reset", 32'(done_o), 0);
    rst_n_i = 1'b1;
    tick;
    chk("idle_after_reset", 32'(busy_o), 0);
    run_seq(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
